// File: rtl/canvas_rmw_saver_if.sv
// Pen-sample handshake and frame-RAM row bus for canvas_rmw_saver.
// master = pen/cursor side plus RAM model, slave = the RMW engine.
interface canvas_rmw_saver_if #(
   parameter int WIDTH    = 640,
   parameter int HEIGHT   = 480,
   parameter int PIX_BITS = 1,
   parameter int ADDR_W   = $clog2(HEIGHT)
);
   logic [10:0]               x;
   logic [10:0]               y;
   logic [PIX_BITS-1:0]       color;
   logic                      erase;
   logic                      save_sw;
   logic                      pen_valid;
   logic                      pen_ready;
   logic                      clear_req;
   logic [ADDR_W-1:0]         read_addr;
   logic [WIDTH*PIX_BITS-1:0] read;
   logic [ADDR_W-1:0]         write_addr;
   logic [WIDTH*PIX_BITS-1:0] data;
   logic                      write_en;
   logic                      busy;

   modport master (
      output x, y, color, erase, save_sw, pen_valid, clear_req, read,
      input  pen_ready, read_addr, write_addr, data, write_en, busy
   );

   modport slave (
      input  x, y, color, erase, save_sw, pen_valid, clear_req, read,
      output pen_ready, read_addr, write_addr, data, write_en, busy
   );
endinterface

// File: rtl/canvas_rmw_saver.sv
// Read-modify-write engine committing pen samples into a row-organised canvas RAM.
// Define CANVAS_SAVER_STATS_EN to add the pix_count committed-pixel counter output.
//
// state   | meaning
// IDLE    | ready for a sample; pending clear takes priority
// RD_WAIT | row read issued, RAM data returns during WRITE
// WRITE   | merge pixel into row and write it back
// CLEAR   | zero rows 0..HEIGHT-1, one per cycle
module canvas_rmw_saver #(
   parameter int WIDTH    = 640,
   parameter int HEIGHT   = 480,
   parameter int PIX_BITS = 1,
   parameter int ADDR_W   = $clog2(HEIGHT)
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   canvas_rmw_saver_if.slave    bus
`ifdef CANVAS_SAVER_STATS_EN
   ,
   output logic [31:0]          pix_count
`endif
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, CLEAR} state_t;

   state_t              state_q, state_d;
   logic [10:0]         x_q;
   logic [ADDR_W-1:0]   y_q;
   logic [PIX_BITS-1:0] color_q;
   logic                erase_q;
   logic                clear_pend_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]   raddr_q;

   logic                clear_now;
   logic                in_range;
   logic                accept;
   logic                commit;
   logic                cnt_last;

   assign clear_now = clear_pend_q | bus.clear_req;
   assign in_range  = ({21'd0, bus.x} < 32'(WIDTH)) && ({21'd0, bus.y} < 32'(HEIGHT));
   assign cnt_last  = (cnt_q == ADDR_W'(HEIGHT - 1));

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_now) begin
               state_d = CLEAR;
            end else if (bus.pen_valid) begin
               accept = 1'b1;
               if (bus.save_sw && in_range) begin
                  commit  = 1'b1;
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: state_d = WRITE;
         WRITE:   state_d = IDLE;
         CLEAR:   if (cnt_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         color_q      <= '0;
         erase_q      <= 1'b0;
         clear_pend_q <= 1'b0;
         cnt_q        <= '0;
         raddr_q      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            x_q     <= bus.x;
            y_q     <= bus.y[ADDR_W-1:0];
            color_q <= bus.color;
            erase_q <= bus.erase;
         end
         if (commit) raddr_q <= bus.y[ADDR_W-1:0];
         // Requests arriving mid-sweep are absorbed; only RMW states latch them.
         if (state_q == CLEAR) begin
            if (cnt_last) clear_pend_q <= 1'b0;
         end else if (state_q != IDLE && bus.clear_req) begin
            clear_pend_q <= 1'b1;
         end
         if (state_q == CLEAR && !cnt_last) cnt_q <= cnt_q + ADDR_W'(1);
         else                               cnt_q <= '0;
      end
   end

`ifdef CANVAS_SAVER_STATS_EN
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pix_count <= '0;
      end else if (state_q == IDLE && state_d == CLEAR) begin
         pix_count <= '0;
      end else if (state_q == WRITE && pix_count != 32'hFFFF_FFFF) begin
         pix_count <= pix_count + 32'd1;
      end
   end
`endif

   logic [WIDTH*PIX_BITS-1:0] row_merged;
   logic [PIX_BITS-1:0]       pix;

   always_comb begin
      pix        = erase_q ? '0 : color_q;
      row_merged = bus.read;
      for (int i = 0; i < WIDTH; i++) begin
         if (x_q == 11'(i)) row_merged[i*PIX_BITS +: PIX_BITS] = pix;
      end
   end

   // Ready is withheld while a clear is pending so no accepted sample is lost.
   assign bus.pen_ready  = (state_q == IDLE) && !clear_now && !reset;
   assign bus.busy       = (state_q != IDLE);
   assign bus.read_addr  = raddr_q;
   assign bus.write_en   = (state_q == WRITE) || (state_q == CLEAR);
   assign bus.write_addr = (state_q == CLEAR) ? cnt_q : y_q;

   always_comb begin
      bus.data = '0;
      if (state_q == WRITE) bus.data = row_merged;
   end

endmodule

// File: tb/tb_canvas_rmw_saver.sv
// Directed bench for canvas_rmw_saver: a 640x480x1 instance and a 16x8x4 instance,
// each backed by a registered-read RAM model.
module tb_canvas_rmw_saver;

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b1;

   always #10 CLOCK_50 = ~CLOCK_50;

   canvas_rmw_saver_if #(.WIDTH(640), .HEIGHT(480), .PIX_BITS(1), .ADDR_W(9)) b1 ();
   canvas_rmw_saver_if #(.WIDTH(16),  .HEIGHT(8),   .PIX_BITS(4), .ADDR_W(3)) b4 ();

`ifdef CANVAS_SAVER_STATS_EN
   logic [31:0] pix_count1, pix_count4;
`endif

   canvas_rmw_saver #(.WIDTH(640), .HEIGHT(480), .PIX_BITS(1), .ADDR_W(9)) dut1 (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (b1)
`ifdef CANVAS_SAVER_STATS_EN
      ,
      .pix_count(pix_count1)
`endif
   );

   canvas_rmw_saver #(.WIDTH(16), .HEIGHT(8), .PIX_BITS(4), .ADDR_W(3)) dut4 (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (b4)
`ifdef CANVAS_SAVER_STATS_EN
      ,
      .pix_count(pix_count4)
`endif
   );

   logic [639:0] mem1 [0:479] = '{default: '0};
   logic [63:0]  mem4 [0:7]   = '{default: '1};
   int           wr_cnt1      = 0;

   always @(posedge CLOCK_50) begin
      if (b1.write_en) mem1[b1.write_addr] <= b1.data;
      b1.read <= mem1[b1.read_addr];
      if (b4.write_en) mem4[b4.write_addr] <= b4.data;
      b4.read <= mem4[b4.read_addr];
      if (b1.write_en) wr_cnt1 <= wr_cnt1 + 1;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLOCK_50);
   endtask

   task automatic pen1(input logic [10:0] xx, input logic [10:0] yy, input logic col,
                       input logic er, input logic sv);
      b1.x = xx; b1.y = yy; b1.color = col; b1.erase = er; b1.save_sw = sv;
      b1.pen_valid = 1'b1;
      step();
      b1.pen_valid = 1'b0;
   endtask

   task automatic pen4(input logic [10:0] xx, input logic [10:0] yy, input logic [3:0] col,
                       input logic er);
      b4.x = xx; b4.y = yy; b4.color = col; b4.erase = er; b4.save_sw = 1'b1;
      b4.pen_valid = 1'b1;
      step();
      b4.pen_valid = 1'b0;
   endtask

   logic [639:0] e_row;
   int           snap;
   int           bad;

   initial begin
      b1.x = '0; b1.y = '0; b1.color = '0; b1.erase = 1'b0; b1.save_sw = 1'b0;
      b1.pen_valid = 1'b0; b1.clear_req = 1'b0;
      b4.x = '0; b4.y = '0; b4.color = '0; b4.erase = 1'b0; b4.save_sw = 1'b0;
      b4.pen_valid = 1'b0; b4.clear_req = 1'b0;

      repeat (3) step();
      chk("rst_ready",  640'(b1.pen_ready),  640'(0));
      chk("rst_busy",   640'(b1.busy),       640'(0));
      chk("rst_we",     640'(b1.write_en),   640'(0));
      chk("rst_raddr",  640'(b1.read_addr),  640'(0));
      chk("rst_waddr",  640'(b1.write_addr), 640'(0));
      chk("rst_data",   b1.data,             640'(0));
      chk("rst_ready4", 640'(b4.pen_ready),  640'(0));
      reset = 1'b0;
      step();
      chk("rel_ready",  640'(b1.pen_ready),  640'(1));
      chk("rel_ready4", 640'(b4.pen_ready),  640'(1));

      // basic draw at (1,1)
      pen1(11'd1, 11'd1, 1'b1, 1'b0, 1'b1);
      chk("rdw_we",    640'(b1.write_en),  640'(0));
      chk("rdw_busy",  640'(b1.busy),      640'(1));
      chk("rdw_raddr", 640'(b1.read_addr), 640'(1));
      chk("rdw_ready", 640'(b1.pen_ready), 640'(0));
      step();
      chk("draw_we",    640'(b1.write_en),   640'(1));
      chk("draw_waddr", 640'(b1.write_addr), 640'(1));
      chk("draw_data",  b1.data,             640'(2));
      step();
      chk("draw_ready_back", 640'(b1.pen_ready), 640'(1));
      chk("draw_we_off",     640'(b1.write_en),  640'(0));

      // last column / last row
      pen1(11'd639, 11'd479, 1'b1, 1'b0, 1'b1);
      step();
      e_row = '0;
      e_row[639] = 1'b1;
      chk("corner_data",  b1.data,             e_row);
      chk("corner_waddr", 640'(b1.write_addr), 640'(479));
      step();

      // dropped samples: gated, x out of range, y out of range, back-to-back
      snap = wr_cnt1;
      b1.pen_valid = 1'b1; b1.save_sw = 1'b0; b1.x = 11'd6; b1.y = 11'd6; b1.color = 1'b1;
      step();
      chk("drop_sw_ready", 640'(b1.pen_ready), 640'(1));
      chk("drop_sw_busy",  640'(b1.busy),      640'(0));
      b1.save_sw = 1'b1; b1.x = 11'd640; b1.y = 11'd0;
      step();
      chk("drop_x_ready", 640'(b1.pen_ready), 640'(1));
      b1.x = 11'd0; b1.y = 11'd480;
      step();
      chk("drop_y_ready", 640'(b1.pen_ready), 640'(1));
      b1.pen_valid = 1'b0;
      step();
      chk("drop_no_write", 640'(wr_cnt1), 640'(snap));

      // 4-bit pixels: erase then draw into a preloaded all-ones row
      pen4(11'd2, 11'd3, 4'h5, 1'b1);
      step();
      chk("erase4_data",  640'(b4.data),       640'(64'hFFFF_FFFF_FFFF_F0FF));
      chk("erase4_waddr", 640'(b4.write_addr), 640'(3));
      step();
      pen4(11'd5, 11'd3, 4'hA, 1'b0);
      step();
      chk("draw4_data", 640'(b4.data), 640'(64'hFFFF_FFFF_FFAF_F0FF));
      step();

      // clear arriving while a pixel is in flight
      pen1(11'd5, 11'd5, 1'b1, 1'b0, 1'b1);
      b1.clear_req = 1'b1;
      step();
      b1.clear_req = 1'b0;
      chk("coll_waddr", 640'(b1.write_addr), 640'(5));
      chk("coll_data",  b1.data,             640'(32));
      step();
      chk("coll_pend_ready", 640'(b1.pen_ready), 640'(0));
      step();
      bad = 0;
      for (int i = 0; i < 480; i++) begin
         if (b1.write_en !== 1'b1 || b1.write_addr !== 9'(i) || b1.data !== '0 ||
             b1.busy !== 1'b1 || b1.pen_ready !== 1'b0) bad++;
         b1.clear_req = (i == 200);
         step();
      end
      b1.clear_req = 1'b0;
      chk("clear_sweep", 640'(bad), 640'(0));
      chk("clear_done_busy",  640'(b1.busy),      640'(0));
      chk("clear_done_ready", 640'(b1.pen_ready), 640'(1));
      step();
      chk("clear_absorbed", 640'(b1.busy), 640'(0));
      chk("clear_row5",   mem1[5],   640'(0));
      chk("clear_row479", mem1[479], 640'(0));

      // reset in the middle of a sweep
      b1.clear_req = 1'b1;
      step();
      b1.clear_req = 1'b0;
      chk("sweep_start", 640'(b1.write_addr), 640'(0));
      repeat (100) step();
      chk("sweep_at_100", 640'(b1.write_addr), 640'(100));
      reset = 1'b1;
      step();
      chk("mid_rst_we",    640'(b1.write_en),   640'(0));
      chk("mid_rst_busy",  640'(b1.busy),       640'(0));
      chk("mid_rst_waddr", 640'(b1.write_addr), 640'(0));
      chk("mid_rst_raddr", 640'(b1.read_addr),  640'(0));
      chk("mid_rst_data",  b1.data,             640'(0));
      chk("mid_rst_ready", 640'(b1.pen_ready),  640'(0));
      snap = wr_cnt1;
      step();
      reset = 1'b0;
      repeat (5) step();
      chk("mid_rst_no_write", 640'(wr_cnt1), 640'(snap));
      chk("mid_rst_ready_back", 640'(b1.pen_ready), 640'(1));

`ifdef CANVAS_SAVER_STATS_EN
      chk("stats_rst", 640'(pix_count1), 640'(0));
      pen1(11'd10, 11'd10, 1'b1, 1'b0, 1'b1); step(); step();
      pen1(11'd11, 11'd10, 1'b1, 1'b0, 1'b1); step(); step();
      pen1(11'd12, 11'd12, 1'b1, 1'b0, 1'b0); step();
      pen1(11'd12, 11'd12, 1'b1, 1'b0, 1'b1); step(); step();
      chk("stats_three", 640'(pix_count1), 640'(3));
      b1.clear_req = 1'b1;
      step();
      b1.clear_req = 1'b0;
      chk("stats_clear", 640'(pix_count1), 640'(0));
      repeat (481) step();
      chk("stats_after_sweep", 640'(pix_count1), 640'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
